// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM modulator/decimator pair: FSM states and the
// default window/sample geometry both ends of the link agree on.
package pdm_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    localparam int DEF_WINDOW_LOG2 = 6;
    localparam int DEF_OUT_W       = 5;

endpackage

// File: rtl/pdm_window_counter.sv
// Window position and ones counter for the decimator. Clear empties the window,
// load starts a fresh window with the current bit as its first bit.
module pdm_window_counter
    import pdm_pkg::*;
#(
    parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic                   load_i,
    input  logic                   inc_i,
    input  logic                   bit_i,
    output logic [WINDOW_LOG2:0]   ones_cnt_o,
    output logic                   last_o
);

    localparam logic [WINDOW_LOG2-1:0] WIN_ONE = {{(WINDOW_LOG2-1){1'b0}}, 1'b1};

    logic [WINDOW_LOG2-1:0] win_cnt_q;
    logic [WINDOW_LOG2:0]   ones_cnt_q;
    logic [WINDOW_LOG2:0]   bit_ext;

    assign bit_ext = {{WINDOW_LOG2{1'b0}}, bit_i};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt_q  <= '0;
            ones_cnt_q <= '0;
        end else if (clear_i) begin
            win_cnt_q  <= '0;
            ones_cnt_q <= '0;
        end else if (load_i) begin
            win_cnt_q  <= WIN_ONE;
            ones_cnt_q <= bit_ext;
        end else if (inc_i) begin
            win_cnt_q  <= win_cnt_q + WIN_ONE;
            ones_cnt_q <= ones_cnt_q + bit_ext;
        end
    end

    assign ones_cnt_o = ones_cnt_q;
    assign last_o     = (win_cnt_q == '1);

endmodule

// File: rtl/pdm_decimator.sv
// Boxcar PDM decimator: counts ones over 2**WINDOW_LOG2 bits and emits a
// saturated OUT_W-bit sample per window, with clip/stable status.
module pdm_decimator
    import pdm_pkg::*;
#(
    parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
    parameter int OUT_W       = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             pdm_in,
    output logic [OUT_W-1:0] sample,
    output logic             sample_valid,
    output logic             clip,
    output logic             stable,
    output logic             busy
);

    generate
        if (WINDOW_LOG2 < OUT_W) begin : g_param_check
            $error("pdm_decimator: WINDOW_LOG2 must be >= OUT_W");
        end
    endgenerate

    localparam int                   SHIFT      = WINDOW_LOG2 - OUT_W;
    localparam int                   FULL_SCALE = (1 << OUT_W) - 1;
    localparam logic [WINDOW_LOG2:0] FULL_W     = (WINDOW_LOG2+1)'(FULL_SCALE);

    state_e           state_q;
    logic [OUT_W-1:0] sample_q;
    logic             sample_valid_q;
    logic             clip_q;
    logic             stable_q;
    logic             have_prev_q;

    logic                 in_accum;
    logic                 last_bit;
    logic                 cnt_clear;
    logic                 cnt_load;
    logic                 cnt_inc;
    logic [WINDOW_LOG2:0] ones_cnt;
    logic [WINDOW_LOG2:0] total;
    logic [WINDOW_LOG2:0] scaled;
    logic [OUT_W-1:0]     sample_d;
    logic                 clip_d;
    logic                 stable_d;

    assign in_accum = (state_q == ST_ACCUM);

    // sync beats the last-bit close, and a dropped enable beats both
    assign cnt_load  = in_accum && enable && sync;
    assign cnt_clear = !in_accum || !enable || (!sync && last_bit);
    assign cnt_inc   = in_accum && enable && !sync && !last_bit;

    pdm_window_counter #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_win_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (cnt_clear),
        .load_i     (cnt_load),
        .inc_i      (cnt_inc),
        .bit_i      (pdm_in),
        .ones_cnt_o (ones_cnt),
        .last_o     (last_bit)
    );

    // total can reach exactly 2**WINDOW_LOG2, which is why it carries one extra bit
    assign total    = ones_cnt + {{WINDOW_LOG2{1'b0}}, pdm_in};
    assign scaled   = total >> SHIFT;
    assign clip_d   = (scaled > FULL_W);
    assign sample_d = clip_d ? '1 : scaled[OUT_W-1:0];
    assign stable_d = have_prev_q && (sample_d == sample_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            clip_q         <= 1'b0;
            stable_q       <= 1'b0;
            have_prev_q    <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_q <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (!sync && last_bit) begin
                        sample_q       <= sample_d;
                        clip_q         <= clip_d;
                        stable_q       <= stable_d;
                        have_prev_q    <= 1'b1;
                        sample_valid_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign clip         = clip_q;
    assign stable       = stable_q;
    assign busy         = in_accum;

endmodule

// File: tb/tb_pdm_decimator.sv
// Scoreboard bench for pdm_decimator: a window-of-bits reference model pushes
// expected samples, a negedge monitor pops and compares on every strobe.
module tb_pdm_decimator;

    localparam int WL    = 6;
    localparam int OW    = 5;
    localparam int WIN   = 1 << WL;
    localparam int SHIFT = WL - OW;
    localparam int FS    = (1 << OW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          sync;
    logic          pdm_in;
    logic [OW-1:0] sample;
    logic          sample_valid;
    logic          clip;
    logic          stable;
    logic          busy;

    always #5 clk = ~clk;

    pdm_decimator #(.WINDOW_LOG2(WL), .OUT_W(OW)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sync         (sync),
        .pdm_in       (pdm_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .clip         (clip),
        .stable       (stable),
        .busy         (busy)
    );

    typedef struct {
        int s;
        bit c;
        bit st;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   strobes = 0;
    bit   mon_on = 1'b0;

    // reference model state: a window is simply the list of bits seen so far
    bit   m_active;
    bit   m_bits[$];
    int   m_sample;
    bit   m_clip;
    bit   m_stable;
    bit   m_have;
    int   mod_acc;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_bits.delete();
        m_sample = 0;
        m_clip   = 1'b0;
        m_stable = 1'b0;
        m_have   = 1'b0;
        sbq.delete();
    endfunction

    function automatic void model_edge(input bit en, input bit sy, input bit b);
        int   ones;
        int   sc;
        exp_t e;
        if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_bits.delete();
            end
        end else if (!en) begin
            m_active = 1'b0;
            m_bits.delete();
        end else if (sy) begin
            m_bits.delete();
            m_bits.push_back(b);
        end else begin
            m_bits.push_back(b);
            if (m_bits.size() == WIN) begin
                ones = 0;
                foreach (m_bits[i]) ones += int'(m_bits[i]);
                sc   = ones >> SHIFT;
                e.c  = (sc > FS);
                e.s  = e.c ? FS : sc;
                e.st = m_have && (e.s == m_sample);
                m_have   = 1'b1;
                m_sample = e.s;
                m_clip   = e.c;
                m_stable = e.st;
                sbq.push_back(e);
                m_bits.delete();
            end
        end
    endfunction

    task automatic step(input bit r, input bit en, input bit sy, input bit b);
        reset  = r;
        enable = en;
        sync   = sy;
        pdm_in = b;
        if (r) model_reset();
        @(posedge clk);
        if (!r) model_edge(en, sy, b);
        #1;
    endtask

    function automatic bit mod_bit(input int v);
        mod_acc += v;
        if (mod_acc >= (1 << OW)) begin
            mod_acc -= (1 << OW);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            chk("busy", int'(busy), int'(m_active));
            if (sample_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    strobes++;
                    chk("strobe_sample", int'(sample), mon_e.s);
                    chk("strobe_clip", int'(clip), int'(mon_e.c));
                    chk("strobe_stable", int'(stable), int'(mon_e.st));
                end
            end else if (sbq.size() != 0) begin
                void'(sbq.pop_front());
                chk("missing_strobe", 0, 1);
            end
            chk("hold_sample", int'(sample), m_sample);
            chk("hold_clip", int'(clip), int'(m_clip));
            chk("hold_stable", int'(stable), int'(m_stable));
        end
    end

    initial begin
        int s0;
        int hold;
        int sv;
        int dens;
        int vals[4];
        vals[0] = 8; vals[1] = 26; vals[2] = 15; vals[3] = 4;
        reset = 1'b1; enable = 1'b0; sync = 1'b0; pdm_in = 1'b0;
        model_reset();
        mod_acc = 0;
        mon_on  = 1'b1;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_clip", int'(clip), 0);
        chk("rst_stable", int'(stable), 0);
        chk("rst_busy", int'(busy), 0);

        // all ones: saturates at full scale
        s0 = strobes;
        repeat (70) step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("ones_strobe_count", strobes - s0, 1);
        chk("ones_sample", int'(sample), FS);
        chk("ones_clip", int'(clip), 1);

        // all zeros, two aligned windows: second one reports stable
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (127) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("zeros_sample", int'(sample), 0);
        chk("zeros_clip", int'(clip), 0);
        chk("zeros_stable", int'(stable), 1);

        // first-order modulator driven by slow-changing codes
        foreach (vals[k]) begin
            for (int i = 0; i < WIN; i++) step(1'b0, 1'b1, (i == 0), mod_bit(vals[k]));
            sv = int'(sample);
            chk("mod_valid", int'(sample_valid), 1);
            chk("mod_near", int'((sv >= vals[k] - 1) && (sv <= vals[k] + 1)), 1);
            chk("mod_clip", int'(clip), 0);
            chk("mod_stable", int'(stable), 0);
        end

        // sync at bit 30 restarts the window
        step(1'b0, 1'b1, 1'b1, 1'($urandom));
        repeat (29) step(1'b0, 1'b1, 1'b0, 1'($urandom));
        s0 = strobes;
        step(1'b0, 1'b1, 1'b1, 1'($urandom));
        repeat (62) step(1'b0, 1'b1, 1'b0, 1'($urandom));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sync30_no_early", strobes - s0, 0);
        step(1'b0, 1'b1, 1'b0, 1'($urandom));
        chk("sync30_strobe", strobes - s0, 1);

        // sync exactly on the last-bit edge discards the window
        for (int n = 0; n < 2 * WIN && m_bits.size() != WIN - 1; n++)
            step(1'b0, 1'b1, 1'b0, 1'($urandom));
        chk("reach_last_bit", m_bits.size(), WIN - 1);
        hold = m_sample;
        s0   = strobes;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("synclast_no_strobe", strobes - s0, 0);
        chk("synclast_hold", int'(sample), hold);

        // reset at bit 40, then re-enable with zeros
        for (int n = 0; n < 2 * WIN && m_bits.size() != 40; n++)
            step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("reach_bit40", m_bits.size(), 40);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_sample", int'(sample), 0);
        chk("mid_rst_clip", int'(clip), 0);
        chk("mid_rst_busy", int'(busy), 0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_idle", int'(busy), 0);
        s0 = strobes;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (WIN - 1) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rearm_no_early", strobes - s0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rearm_strobe", strobes - s0, 1);
        chk("rearm_sample", int'(sample), 0);
        chk("rearm_stable", int'(stable), 0);

        // random enable drops, syncs and densities
        dens = 128;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dens = $urandom_range(0, 256);
            step(1'b0, ($urandom % 64) != 0, ($urandom % 150) == 0,
                 int'($urandom_range(0, 255)) < dens);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("scoreboard_empty", sbq.size(), 0);
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdm_decimator.md
PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 Parameter WINDOW_LOG2, default 6: log2 of bits per decimation window (64).
REQ-002 Parameter OUT_W, default 5: sample width; full scale = 2**OUT_W - 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  level; 1 = decimate, 0 = idle.
REQ-006 sync  input  1  pulse; restarts window alignment.
REQ-007 pdm_in  input  1  PDM bitstream from the upstream pulse-density modulator.
REQ-008 sample  output  OUT_W  last decimated value, held between windows.
REQ-009 sample_valid  output  1  one-cycle strobe; sample updated this cycle.
REQ-010 clip  output  1  last sample saturated at full scale.
REQ-011 stable  output  1  last two samples equal.
REQ-012 busy  output  1  high while in ACCUM.

Function
REQ-013 FSM SHALL have two states, IDLE and ACCUM; busy = (state == ACCUM).
REQ-014 IDLE: enable=1 at an edge -> ACCUM, win_cnt=0, ones_cnt=0; pdm_in that edge not counted.
REQ-015 ACCUM, enable=0 at an edge -> IDLE; partial window discarded; sample/clip/stable held; no strobe.
REQ-016 ACCUM, no sync, not last bit: win_cnt += 1, ones_cnt += pdm_in.
REQ-017 win_cnt SHALL be WINDOW_LOG2 bits; ones_cnt WINDOW_LOG2+1 bits (holds 2**WINDOW_LOG2 without overflow).
REQ-018 Last bit (win_cnt == 2**WINDOW_LOG2-1, no sync): total = ones_cnt + pdm_in; scaled = total >> (WINDOW_LOG2-OUT_W); sample <= min(scaled, 2**OUT_W-1); clip <= (scaled > 2**OUT_W-1); sample_valid <= 1; win_cnt, ones_cnt <= 0.
REQ-019 Latency: sample_valid high the cycle after the edge sampling the 64th window bit; strobe exactly one cycle wide; first strobe 64 edges after the IDLE->ACCUM edge.
REQ-020 Same final edge: stable <= (new sample == previous sample) AND a previous sample exists since reset; first sample after reset gives stable=0.
REQ-021 sync=1 in ACCUM: win_cnt <= 1, ones_cnt <= pdm_in (sync-edge bit is first bit of new window); no strobe.
REQ-022 sync on the last-bit edge: sync wins; window discarded, no strobe, sample held.
REQ-023 sync in IDLE: ignored; sync with enable=0 in ACCUM: enable wins (-> IDLE).
REQ-024 Continuous windows back-to-back with no gap cycle; strobes every 64 cycles.
REQ-025 Elaboration SHALL fail if WINDOW_LOG2 < OUT_W.

Reset
REQ-026 reset=1 SHALL immediately force: state IDLE, win_cnt 0, ones_cnt 0, sample 0, sample_valid 0, clip 0, stable 0, busy 0, previous-sample-valid flag 0.
REQ-027 Reset mid-window discards partial window; after release, block waits in IDLE for enable.

Structure
REQ-028 Shared package pdm_pkg SHALL hold the FSM state enum and default WINDOW_LOG2/OUT_W constants, shared with the upstream modulator.
REQ-029 One sub-module, pdm_window_counter (win_cnt/ones_cnt with clear, load, last-bit flag); FSM and output registers in the top.

Verification
REQ-030 pdm_in constant 1, enable=1 for 70 cycles -> strobe at cycle 64, sample=31, clip=1.
REQ-031 pdm_in constant 0 -> sample=0, clip=0; second window -> stable=1.
REQ-032 Upstream modulator fed 0x08, then 0x1a, then 0x0f, then 0x04, 64 cycles each, window aligned by sync -> samples 8, 26, 15, 4 (+/-1), clip=0, stable=0 on each change.
REQ-033 sync at bit 30 of a window -> no strobe for that window; next strobe exactly 64 cycles after sync edge.
REQ-034 sync coincident with the last-bit edge -> no strobe, sample unchanged.
REQ-035 reset at bit 40, then enable -> all outputs 0 during reset; first strobe 64 cycles after re-enable; stable=0.
